// File: rtl/mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_stage                                                         |
// | MEM pipeline stage: load/store to data-memory bus with stall, timeout,   |
// | byte/half/word formatting. Optional macro: MEM_ALIGN_CHECK_EN rejects    |
// | misaligned half/word accesses instead of forcing them aligned.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] ALUResIn,
  input  logic [31:0] storeDataIn,
  input  logic        MemRE,
  input  logic        MemWE,
  input  logic [1:0]  MemSize,
  input  logic        MemSignExt,
  input  logic [1:0]  WriteDataSrcIn,
  input  logic [4:0]  WriteRegAddrIn,
  input  logic        RegWE,
  input  logic [31:0] PCplus8,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] dataMemOut,
  output logic [31:0] ALUResOut,
  output logic [1:0]  WriteDataSrcOut,
  output logic [4:0]  WriteRegAddrOut,
  output logic [31:0] PCplus8_out,
  output logic        RegWE_out,
  output logic        stall,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic        r_sext;

  logic        w_access;
  logic        w_reject;
  logic        w_is_half;
  logic        w_is_word;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;
  logic [31:0] w_load;
  logic        w_err_op;

  assign w_access  = valid_in & (MemRE | MemWE);
  assign w_is_half = (MemSize == 2'b01);
  assign w_is_word = MemSize[1];

`ifdef MEM_ALIGN_CHECK_EN
  assign w_reject = w_access &
                    ((w_is_half & ALUResIn[0]) | (w_is_word & (ALUResIn[1:0] != 2'b00)));
`else
  assign w_reject = 1'b0;
`endif

  // Lane is forced aligned for half/word; with the check enabled such accesses never issue.
  always_comb begin
    w_lane  = ALUResIn[1:0];
    w_be    = 4'b0001 << ALUResIn[1:0];
    w_wdata = {4{storeDataIn[7:0]}};
    if (w_is_word) begin
      w_lane  = 2'b00;
      w_be    = 4'b1111;
      w_wdata = storeDataIn;
    end else if (w_is_half) begin
      w_lane  = {ALUResIn[1], 1'b0};
      w_be    = ALUResIn[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{storeDataIn[15:0]}};
    end
  end

  always_comb begin
    w_rhalf = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_lane)
      2'd0:    w_rbyte = dmem_rdata[7:0];
      2'd1:    w_rbyte = dmem_rdata[15:8];
      2'd2:    w_rbyte = dmem_rdata[23:16];
      default: w_rbyte = dmem_rdata[31:24];
    endcase
    if (r_size[1]) begin
      w_load = dmem_rdata;
    end else if (r_size[0]) begin
      w_load = {{16{r_sext & w_rhalf[15]}}, w_rhalf};
    end else begin
      w_load = {{24{r_sext & w_rbyte[7]}}, w_rbyte};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_err      <= 1'b0;
      r_size     <= 2'b00;
      r_lane     <= 2'b00;
      r_sext     <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'd0;
      dataMemOut <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access && !w_reject) begin
            r_state    <= S_BUSY;
            r_cnt      <= 8'd0;
            r_err      <= 1'b0;
            r_size     <= MemSize;
            r_lane     <= w_lane;
            r_sext     <= MemSignExt;
            dmem_req   <= 1'b1;
            dmem_we    <= MemWE;
            dmem_addr  <= {ALUResIn[31:2], 2'b00};
            dmem_wdata <= w_wdata;
            dmem_be    <= w_be;
          end
        end
        S_BUSY: begin
          // Ack wins over a timeout landing on the same cycle.
          if (dmem_ack) begin
            r_state  <= S_DONE;
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              dataMemOut <= w_load;
            end
          end else if (r_cnt == C_CNT_LAST) begin
            r_state    <= S_DONE;
            dmem_req   <= 1'b0;
            dataMemOut <= 32'd0;
            r_err      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_err   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall    = ((r_state == S_IDLE) & w_access & !w_reject) | (r_state == S_BUSY);
  assign w_err_op = ((r_state == S_DONE) & r_err) | ((r_state == S_IDLE) & w_reject);
  assign mem_err  = w_err_op;
  assign RegWE_out = RegWE & !stall & !w_err_op;

  assign ALUResOut       = ALUResIn;
  assign WriteDataSrcOut = WriteDataSrcIn;
  assign WriteRegAddrOut = WriteRegAddrIn;
  assign PCplus8_out     = PCplus8;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_stage                                                      |
// | Directed self-checking bench for mem_access_stage (MEM_ALIGN_CHECK_EN    |
// | aware).                                                                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] ALUResIn = '0;
  logic [31:0] storeDataIn = '0;
  logic        MemRE = 1'b0;
  logic        MemWE = 1'b0;
  logic [1:0]  MemSize = '0;
  logic        MemSignExt = 1'b0;
  logic [1:0]  WriteDataSrcIn = '0;
  logic [4:0]  WriteRegAddrIn = '0;
  logic        RegWE = 1'b0;
  logic [31:0] PCplus8 = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dataMemOut, ALUResOut, PCplus8_out;
  logic [1:0]  WriteDataSrcOut;
  logic [4:0]  WriteRegAddrOut;
  logic        RegWE_out, stall, mem_err;

  int total = 0;
  int bad   = 0;
  int cnt;

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ALUResIn(ALUResIn),
    .storeDataIn(storeDataIn), .MemRE(MemRE), .MemWE(MemWE), .MemSize(MemSize),
    .MemSignExt(MemSignExt), .WriteDataSrcIn(WriteDataSrcIn),
    .WriteRegAddrIn(WriteRegAddrIn), .RegWE(RegWE), .PCplus8(PCplus8),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .dataMemOut(dataMemOut), .ALUResOut(ALUResOut),
    .WriteDataSrcOut(WriteDataSrcOut), .WriteRegAddrOut(WriteRegAddrOut),
    .PCplus8_out(PCplus8_out), .RegWE_out(RegWE_out), .stall(stall),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; MemRE = 1'b0; MemWE = 1'b0; dmem_ack = 1'b0;
  endtask

  initial begin
    // Reset state, feed-throughs active during reset
    ALUResIn = 32'h1234_5678; RegWE = 1'b1; valid_in = 1'b1;
    #3;
    chk("rst_req",   {31'd0, dmem_req}, 32'd0);
    chk("rst_we",    {31'd0, dmem_we}, 32'd0);
    chk("rst_addr",  dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_be",    {28'd0, dmem_be}, 32'd0);
    chk("rst_dout",  dataMemOut, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_err",   {31'd0, mem_err}, 32'd0);
    chk("rst_alufw", ALUResOut, 32'h1234_5678);
    chk("rst_regwe", {31'd0, RegWE_out}, 32'd1);
    tick(); tick();
    rst = 1'b1;

    // Non-access pass-through
    valid_in = 1'b1; ALUResIn = 32'hA5A5_0001; WriteDataSrcIn = 2'd2;
    WriteRegAddrIn = 5'd17; PCplus8 = 32'h0000_0408; RegWE = 1'b1;
    #1;
    chk("pt_alu",   ALUResOut, 32'hA5A5_0001);
    chk("pt_wds",   {30'd0, WriteDataSrcOut}, 32'd2);
    chk("pt_wra",   {27'd0, WriteRegAddrOut}, 32'd17);
    chk("pt_pc8",   PCplus8_out, 32'h0000_0408);
    chk("pt_regwe", {31'd0, RegWE_out}, 32'd1);
    chk("pt_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("pt_noreq", {31'd0, dmem_req}, 32'd0);

    // Word load 0x100, ack after one BUSY cycle
    MemRE = 1'b1; MemSize = 2'b10; ALUResIn = 32'h100; MemSignExt = 1'b0;
    #1;
    chk("wl_stall_idle", {31'd0, stall}, 32'd1);
    chk("wl_regwe_idle", {31'd0, RegWE_out}, 32'd0);
    tick();
    chk("wl_req",  {31'd0, dmem_req}, 32'd1);
    chk("wl_we",   {31'd0, dmem_we}, 32'd0);
    chk("wl_addr", dmem_addr, 32'h100);
    chk("wl_be",   {28'd0, dmem_be}, 32'hF);
    chk("wl_stall_busy", {31'd0, stall}, 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("wl_req_done", {31'd0, dmem_req}, 32'd0);
    chk("wl_dout",  dataMemOut, 32'hDEAD_BEEF);
    chk("wl_stall_done", {31'd0, stall}, 32'd0);
    chk("wl_regwe_done", {31'd0, RegWE_out}, 32'd1);
    chk("wl_err",   {31'd0, mem_err}, 32'd0);
    idle_inputs();
    tick();
    chk("wl_hold", dataMemOut, 32'hDEAD_BEEF);

    // Byte load 0x103 sign-extended
    valid_in = 1'b1; MemRE = 1'b1; MemSize = 2'b00; ALUResIn = 32'h103; MemSignExt = 1'b1;
    tick();
    chk("bl_be", {28'd0, dmem_be}, 32'h8);
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FFFF;
    tick();
    chk("bl_sext", dataMemOut, 32'hFFFF_FF80);
    idle_inputs();
    tick();
    // Same byte load zero-extended
    valid_in = 1'b1; MemRE = 1'b1; MemSignExt = 1'b0;
    tick();
    dmem_ack = 1'b1;
    tick();
    chk("bl_zext", dataMemOut, 32'h0000_0080);
    idle_inputs();
    tick();

    // Half load 0x102 sign-extended: upper half 0x8001
    valid_in = 1'b1; MemRE = 1'b1; MemSize = 2'b01; ALUResIn = 32'h102; MemSignExt = 1'b1;
    tick();
    chk("hl_be", {28'd0, dmem_be}, 32'hC);
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_7FFF;
    tick();
    chk("hl_sext", dataMemOut, 32'hFFFF_8001);
    idle_inputs();
    tick();

    // Half store 0x202
    valid_in = 1'b1; MemWE = 1'b1; MemSize = 2'b01; ALUResIn = 32'h202;
    storeDataIn = 32'h1234_ABCD; RegWE = 1'b0;
    tick();
    chk("hs_we",    {31'd0, dmem_we}, 32'd1);
    chk("hs_be",    {28'd0, dmem_be}, 32'hC);
    chk("hs_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("hs_addr",  dmem_addr, 32'h200);
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    tick();
    chk("hs_dout_hold", dataMemOut, 32'hFFFF_8001);
    chk("hs_regwe", {31'd0, RegWE_out}, 32'd0);
    idle_inputs();
    tick();

    // Byte store 0x101
    valid_in = 1'b1; MemWE = 1'b1; MemSize = 2'b00; ALUResIn = 32'h101; storeDataIn = 32'h0000_005A;
    tick();
    chk("bs_be",    {28'd0, dmem_be}, 32'h2);
    chk("bs_wdata", dmem_wdata, 32'h5A5A_5A5A);
    dmem_ack = 1'b1;
    tick();
    idle_inputs();
    tick();

    // Timeout: word load without ack
    valid_in = 1'b1; MemRE = 1'b1; MemSize = 2'b10; ALUResIn = 32'h300; RegWE = 1'b1;
    tick();
    cnt = 0;
    while (dmem_req && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("to_busy_cycles", cnt, 32'd16);
    chk("to_err",   {31'd0, mem_err}, 32'd1);
    chk("to_dout",  dataMemOut, 32'd0);
    chk("to_regwe", {31'd0, RegWE_out}, 32'd0);
    chk("to_stall", {31'd0, stall}, 32'd0);
    idle_inputs();
    tick();
    chk("to_err_clr", {31'd0, mem_err}, 32'd0);

    // Misaligned word load 0x101
    valid_in = 1'b1; MemRE = 1'b1; MemSize = 2'b10; ALUResIn = 32'h101; RegWE = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    chk("ma_err",   {31'd0, mem_err}, 32'd1);
    chk("ma_stall", {31'd0, stall}, 32'd0);
    chk("ma_regwe", {31'd0, RegWE_out}, 32'd0);
    tick();
    chk("ma_noreq", {31'd0, dmem_req}, 32'd0);
`else
    chk("ma_stall", {31'd0, stall}, 32'd1);
    chk("ma_err",   {31'd0, mem_err}, 32'd0);
    tick();
    chk("ma_addr",  dmem_addr, 32'h100);
    chk("ma_be",    {28'd0, dmem_be}, 32'hF);
    tick();
    chk("ma_req_wait", {31'd0, dmem_req}, 32'd1);
    dmem_ack = 1'b1;
    tick();
    chk("ma_dout",  dataMemOut, 32'hCAFE_F00D);
    chk("ma_regwe", {31'd0, RegWE_out}, 32'd1);
`endif
    idle_inputs();
    tick();

    // Reset asserted during BUSY
    valid_in = 1'b1; MemRE = 1'b1; MemSize = 2'b10; ALUResIn = 32'h400;
    tick();
    chk("rb_req", {31'd0, dmem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rb_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("rb_dout",     dataMemOut, 32'd0);
    chk("rb_stall",    {31'd0, stall}, 32'd1);
    idle_inputs();
    dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
    tick();
    rst = 1'b1;
    tick();
    chk("rb_no_done", dataMemOut, 32'd0);
    chk("rb_idle_req", {31'd0, dmem_req}, 32'd0);
    dmem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
